// File: rtl/tm1638_frame_builder.sv
// TM1638 frame builder: snapshots 8 hex digits, dots and LEDs and streams the 19-byte command/data frame.
// Latency: first byte valid 1 cycle after the start edge; then one byte per accepted handshake, no bubbles.
// Backpressure: byte_data/byte_last hold while byte_valid & !byte_ready; valid only drops after a transfer or reset.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   digits_in/dots_in/    - display content, captured at frame start
//   leds_in
//   update                - one-cycle request for a new frame (queued as pending while busy)
//   byte_data/byte_valid/ - byte stream toward the TM1638 controller
//   byte_ready/byte_last    (byte_last marks the end of a strobe group)
//   busy, frame_done      - frame in progress / one-cycle completion pulse
module tm1638_frame_builder #(
  parameter logic [2:0] BRIGHTNESS  = 3'd7,
  parameter int         REFRESH_DIV = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dots_in,
  input  logic [7:0]  leds_in,
  input  logic        update,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_last,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic [31:0]   snap_digits_q, snap_digits_d;
  logic [7:0]    snap_dots_q, snap_dots_d;
  logic [7:0]    snap_leds_q, snap_leds_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic          byte_valid_q, byte_valid_d;
  logic          byte_last_q, byte_last_d;

  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h71;
    endcase
  endfunction

  // Returns {byte_last, byte_data} for frame position idx.
  function automatic logic [8:0] frame_byte(input logic [4:0]  idx,
                                            input logic [31:0] dg,
                                            input logic [7:0]  dt,
                                            input logic [7:0]  ld);
    logic [3:0] a;
    logic [2:0] k;
    frame_byte = 9'h000;
    // RAM address = idx-2; modulo-16 arithmetic on idx[3:0] maps 16/17 to 14/15.
    a = idx[3:0] - 4'd2;
    k = a[3:1];
    case (idx)
      5'd0:    frame_byte = {1'b1, 8'h40};
      5'd1:    frame_byte = {1'b0, 8'hC0};
      5'd18:   frame_byte = {1'b1, 8'h88 | {5'b0, BRIGHTNESS}};
      default: begin
        if (!a[0]) frame_byte = {1'b0, dt[k], seg7(dg[{k, 2'b00} +: 4])};
        else       frame_byte = {1'b0, 7'b0, ld[k]};
        if (idx == 5'd17) frame_byte[8] = 1'b1;
      end
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    pending_d     = pending_q;
    snap_digits_d = snap_digits_q;
    snap_dots_d   = snap_dots_q;
    snap_leds_d   = snap_leds_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = byte_valid_q;
    byte_last_d   = byte_last_q;
    busy          = 1'b0;
    frame_done    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = cnt_q + CW'(1);
        if (pending_q || update || cnt_q == CW'(REFRESH_DIV - 1)) begin
          snap_digits_d = digits_in;
          snap_dots_d   = dots_in;
          snap_leds_d   = leds_in;
          pending_d     = 1'b0;
          cnt_d         = '0;
          idx_d         = 5'd0;
          state_d       = SEND;
          // Byte 0 is a constant, so it can be loaded alongside the snapshot.
          {byte_last_d, byte_data_d} = frame_byte(5'd0, digits_in, dots_in, leds_in);
          byte_valid_d  = 1'b1;
        end
      end
      SEND: begin
        busy = 1'b1;
        if (update) pending_d = 1'b1;
        if (byte_valid_q && byte_ready) begin
          if (idx_q == 5'd18) begin
            state_d      = DONE;
            byte_valid_d = 1'b0;
          end else begin
            idx_d = idx_q + 5'd1;
            {byte_last_d, byte_data_d} =
              frame_byte(idx_q + 5'd1, snap_digits_q, snap_dots_q, snap_leds_q);
          end
        end
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        if (update) pending_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= 5'd0;
      cnt_q         <= '0;
      pending_q     <= 1'b1;
      snap_digits_q <= 32'h0;
      snap_dots_q   <= 8'h0;
      snap_leds_q   <= 8'h0;
      byte_data_q   <= 8'h0;
      byte_valid_q  <= 1'b0;
      byte_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      snap_digits_q <= snap_digits_d;
      snap_dots_q   <= snap_dots_d;
      snap_leds_q   <= snap_leds_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      byte_last_q   <= byte_last_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign byte_last  = byte_last_q;

endmodule
